turbo_rsc_encoder: RTL and testbench

//  Turbo encoder core downstream of the interleaving input stage. Consumes the

---
 rtl/turbo_rsc_encoder_if.sv | 25 ++
 rtl/turbo_rsc_encoder.sv | 139 +++++++++++++
 tb/tb_turbo_rsc_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/turbo_rsc_encoder_if.sv
// Stream bundle between the interleaving input stage and the turbo RSC encoder core.
// The master drives the input-stage bits and flags; the slave returns the encoded streams.
interface turbo_rsc_encoder_if;
    logic bin_in;
    logic bin_int_in;
    logic valid_in;
    logic mode_in;
    logic sys_out;
    logic par1_out;
    logic par2_out;
    logic tail2_out;
    logic out_valid;
    logic out_tail;
    logic len_err;

    modport master (
        output bin_in, bin_int_in, valid_in, mode_in,
        input  sys_out, par1_out, par2_out, tail2_out, out_valid, out_tail, len_err
    );

    modport slave (
        input  bin_in, bin_int_in, valid_in, mode_in,
        output sys_out, par1_out, par2_out, tail2_out, out_valid, out_tail, len_err
    );
endinterface

// File: rtl/turbo_rsc_encoder.sv
// Two 8-state RSC encoders (g0 = 1+D^2+D^3, g1 = 1+D+D^3) with 3-step trellis termination.
// All outputs are registered, so each sampled input appears on the outputs one cycle later.
module turbo_rsc_encoder #(
    parameter int unsigned BLOCK_LEN = 4096,
    parameter int unsigned CNT_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    turbo_rsc_encoder_if.slave bus
);
    // TERMn means tail step n is currently showing on the registered outputs.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENCODE = 3'd1;
    localparam logic [2:0] ST_TERM1  = 3'd2;
    localparam logic [2:0] ST_TERM2  = 3'd3;
    localparam logic [2:0] ST_TERM3  = 3'd4;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(BLOCK_LEN);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       enc1_q, enc1_d;  // [0] = s1 (newest), [2] = s3
    logic [2:0]       enc2_q, enc2_d;
    logic             armed_q, armed_d;
    logic             sys_q, sys_d, par1_q, par1_d, par2_q, par2_d, tail2_q, tail2_d;
    logic             valid_q, valid_d, tail_q, tail_d, len_err_q, len_err_d;

    logic do_enc, do_tail, start_term;
    logic u1, u2, f1, f2, z1, z2;

    always_comb begin
        do_enc     = 1'b0;
        do_tail    = 1'b0;
        start_term = 1'b0;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in && !bus.mode_in) begin
                    do_enc  = 1'b1;
                    state_d = ST_ENCODE;
                end
            end
            ST_ENCODE, ST_TERM3: begin
                state_d = ST_ENCODE;
                // A mode_in level left over from the previous tail must drop before it counts.
                if (bus.mode_in && armed_q) begin
                    start_term = 1'b1;
                    do_tail    = 1'b1;
                    state_d    = ST_TERM1;
                end else if (bus.valid_in) begin
                    do_enc = 1'b1;
                end
            end
            ST_TERM1: begin
                do_tail = 1'b1;
                state_d = ST_TERM2;
            end
            ST_TERM2: begin
                do_tail = 1'b1;
                state_d = ST_TERM3;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tail input u = s2 ^ s3 cancels the feedback, driving the register to zero.
    always_comb begin
        u1     = do_tail ? (enc1_q[1] ^ enc1_q[2]) : bus.bin_in;
        u2     = do_tail ? (enc2_q[1] ^ enc2_q[2]) : bus.bin_int_in;
        f1     = u1 ^ enc1_q[1] ^ enc1_q[2];
        f2     = u2 ^ enc2_q[1] ^ enc2_q[2];
        z1     = f1 ^ enc1_q[0] ^ enc1_q[2];
        z2     = f2 ^ enc2_q[0] ^ enc2_q[2];
        enc1_d = (do_enc || do_tail) ? {enc1_q[1:0], f1} : enc1_q;
        enc2_d = (do_enc || do_tail) ? {enc2_q[1:0], f2} : enc2_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_TERM2) begin
            cnt_d = '0;
        end else if (do_enc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        armed_d = armed_q;
        if (!bus.mode_in) begin
            armed_d = 1'b1;
        end else if (start_term) begin
            armed_d = 1'b0;
        end

        sys_d     = do_enc ? bus.bin_in : (do_tail ? u1 : 1'b0);
        par1_d    = (do_enc || do_tail) ? z1 : 1'b0;
        par2_d    = (do_enc || do_tail) ? z2 : 1'b0;
        tail2_d   = do_tail ? u2 : 1'b0;
        valid_d   = do_enc || do_tail;
        tail_d    = do_tail;
        len_err_d = start_term && (cnt_q != CntMax);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            enc1_q    <= '0;
            enc2_q    <= '0;
            armed_q   <= 1'b0;
            sys_q     <= 1'b0;
            par1_q    <= 1'b0;
            par2_q    <= 1'b0;
            tail2_q   <= 1'b0;
            valid_q   <= 1'b0;
            tail_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            enc1_q    <= enc1_d;
            enc2_q    <= enc2_d;
            armed_q   <= armed_d;
            sys_q     <= sys_d;
            par1_q    <= par1_d;
            par2_q    <= par2_d;
            tail2_q   <= tail2_d;
            valid_q   <= valid_d;
            tail_q    <= tail_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.sys_out   = sys_q;
    assign bus.par1_out  = par1_q;
    assign bus.par2_out  = par2_q;
    assign bus.tail2_out = tail2_q;
    assign bus.out_valid = valid_q;
    assign bus.out_tail  = tail_q;
    assign bus.len_err   = len_err_q;
endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Directed-plus-random bench for turbo_rsc_encoder; expected streams come from a feedback-history
// model of the two RSC codes and a block/tail sequencing model.
module tb_turbo_rsc_encoder;
    localparam int unsigned BlockLen = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    turbo_rsc_encoder_if bus_if ();

    turbo_rsc_encoder #(
        .BLOCK_LEN(BlockLen),
        .CNT_W    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // fb[e][k] is the feedback bit produced at step k; three leading zeros give the empty register.
    bit fb [2][0:1023];
    int n [2];
    int count;
    int tail_left;
    bit in_block;
    bit armed;

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 3; i++) fb[e][i] = 1'b0;
            n[e] = 3;
        end
        count     = 0;
        tail_left = 0;
        in_block  = 1'b0;
        armed     = 1'b0;
    endtask

    task automatic rsc_step(input int e, input bit tail, input bit u_data,
                            output bit x, output bit z);
        bit u, f;
        u = tail ? (fb[e][n[e]-2] ^ fb[e][n[e]-3]) : u_data;
        f = u ^ fb[e][n[e]-2] ^ fb[e][n[e]-3];
        z = f ^ fb[e][n[e]-1] ^ fb[e][n[e]-3];
        fb[e][n[e]] = f;
        n[e]++;
        x = u;
    endtask

    // Expected {sys, par1, par2, tail2, out_valid, out_tail, len_err} for one sampled input cycle.
    task automatic model_cycle(input bit v, input bit m, input bit b, input bit bi,
                               output logic [6:0] exp);
        bit x1, z1, x2, z2, lerr;
        exp = '0;
        if (tail_left > 0) begin
            rsc_step(0, 1'b1, 1'b0, x1, z1);
            rsc_step(1, 1'b1, 1'b0, x2, z2);
            tail_left--;
            if (tail_left == 0) count = 0;
            exp = {x1, z1, z2, x2, 1'b1, 1'b1, 1'b0};
        end else if (in_block && m && armed) begin
            lerr = (count != BlockLen);
            rsc_step(0, 1'b1, 1'b0, x1, z1);
            rsc_step(1, 1'b1, 1'b0, x2, z2);
            tail_left = 2;
            armed     = 1'b0;
            exp = {x1, z1, z2, x2, 1'b1, 1'b1, lerr};
        end else if (v && (in_block || !m)) begin
            in_block = 1'b1;
            rsc_step(0, 1'b0, b, x1, z1);
            rsc_step(1, 1'b0, bi, x2, z2);
            if (count < BlockLen) count++;
            exp = {b, z1, z2, 1'b0, 1'b1, 1'b0, 1'b0};
        end
        if (!m) armed = 1'b1;
    endtask

    function automatic logic [6:0] outs();
        return {bus_if.sys_out, bus_if.par1_out, bus_if.par2_out, bus_if.tail2_out,
                bus_if.out_valid, bus_if.out_tail, bus_if.len_err};
    endfunction

    task automatic tick(input bit v, input bit m, input bit b, input bit bi, input string tag);
        logic [6:0] exp, got;
        bus_if.valid_in   = v;
        bus_if.mode_in    = m;
        bus_if.bin_in     = b;
        bus_if.bin_int_in = bi;
        model_cycle(v, m, b, bi, exp);
        @(posedge clk);
        #1;
        got = outs();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [6:0] got;
        got = outs();
        checks++;
        assert (got === 7'b0) else begin
            errors++;
            $error("FAIL %s: observed %b expected 0000000", tag, got);
        end
    endtask

    task automatic data_block(input int nbits, input string tag);
        for (int i = 0; i < nbits; i++) begin
            tick(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), tag);
        end
    endtask

    task automatic terminate(input int mode_cycles, input string tag);
        for (int i = 0; i < mode_cycles; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset             = 1'b0;
        bus_if.valid_in   = 1'b0;
        bus_if.mode_in    = 1'b0;
        bus_if.bin_in     = 1'b0;
        bus_if.bin_int_in = 1'b0;
        model_reset();

        // Reset held with toggling inputs.
        for (int i = 0; i < 4; i++) begin
            bus_if.valid_in   = 1'($urandom_range(1));
            bus_if.mode_in    = 1'($urandom_range(1));
            bus_if.bin_in     = 1'($urandom_range(1));
            bus_if.bin_int_in = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        bus_if.valid_in = 1'b0;
        bus_if.mode_in  = 1'b0;
        reset           = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b1, "idle");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "idle_mode");
        tick(1'b1, 1'b1, 1'b1, 1'b1, "idle_mode_valid");

        // Impulse response: parity 1,1,1,1,0.
        tick(1'b1, 1'b0, 1'b1, 1'b0, "impulse");
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, "impulse");
        terminate(3, "impulse_tail");

        // Single bit then tail: x=0,1,1 z=1,0,1 with len_err.
        tick(1'b1, 1'b0, 1'b1, 1'b1, "single");
        terminate(3, "single_tail");

        // Two full blocks back to back.
        data_block(BlockLen, "block1");
        terminate(3, "block1_tail");
        data_block(BlockLen, "block2");
        terminate(3, "block2_tail");

        // Valid gap of two cycles mid-block.
        data_block(3, "gap_pre");
        tick(1'b0, 1'b0, 1'b1, 1'b1, "gap");
        tick(1'b0, 1'b0, 1'b1, 1'b0, "gap");
        data_block(BlockLen - 3, "gap_post");
        terminate(3, "gap_tail");

        // Saturating counter and mode held past the tail.
        data_block(BlockLen + 3, "sat");
        terminate(5, "sat_tail_long");
        data_block(2, "after_long");
        terminate(3, "after_long_tail");

        // Asynchronous reset while the tail is in flight.
        data_block(3, "pre_rst");
        terminate(2, "pre_rst_tail");
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        bus_if.mode_in = 1'b0;
        @(posedge clk);
        #1;
        check_zero("async_rst_hold");
        reset = 1'b1;
        data_block(BlockLen, "post_rst");
        terminate(3, "post_rst_tail");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
